// File: rtl/mcu_sequencer.sv
// Issue stage for the mcu ALU/memory block: program store, 8-entry register file
// and a fetch/decode/issue/writeback FSM talking to the mcu over valid/ready.
module mcu_sequencer #(
  parameter int OP_SZ      = 32,
  parameter int PROG_DEPTH = 16,
  parameter int REG_N      = 8,
  localparam int PW        = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [15:0]      prog_data,
  input  logic             start,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [3:0]       iss_op_code,
  output logic [OP_SZ-1:0] iss_op0,
  output logic [OP_SZ-1:0] iss_op2,
  input  logic             res_valid,
  input  logic [OP_SZ-1:0] res_data,
  input  logic             res_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [PW-1:0]    err_pc,
  input  logic [2:0]       dbg_sel,
  output logic [OP_SZ-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [3:0]    OPC_DIV   = 4'd3;
  localparam logic [3:0]    OPC_STORE = 4'd8;
  localparam logic [3:0]    OPC_LDI   = 4'd9;
  localparam logic [3:0]    OPC_HALT  = 4'd15;
  localparam logic [PW-1:0] PC_LAST   = PW'(PROG_DEPTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_pc;
  logic [15:0]      r_prog [PROG_DEPTH];
  logic [15:0]      r_instr;
  logic [OP_SZ-1:0] r_regs [REG_N];
  logic [OP_SZ-1:0] r_wb_data;
  logic             r_iss_valid;
  logic [3:0]       r_iss_op_code;
  logic [OP_SZ-1:0] r_iss_op0;
  logic [OP_SZ-1:0] r_iss_op2;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [PW-1:0]    r_err_pc;

  logic             w_idle_like;
  logic             w_start_ok;
  logic             w_we_ok;
  logic [3:0]       w_opc;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs0;
  logic [2:0]       w_rs2;
  logic [OP_SZ-1:0] w_rs0_val;
  logic [OP_SZ-1:0] w_rs2_val;
  logic             w_unused_spare;

  assign w_idle_like    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_start_ok     = w_idle_like && start;
  assign w_we_ok        = w_idle_like && prog_we;
  assign w_opc          = r_instr[15:12];
  assign w_rd           = r_instr[11:9];
  assign w_rs0          = r_instr[8:6];
  assign w_rs2          = r_instr[5:3];
  assign w_unused_spare = ^r_instr[2:0];
  // r0 is never written, so a plain array read already returns zero for it
  assign w_rs0_val      = r_regs[w_rs0];
  assign w_rs2_val      = r_regs[w_rs2];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_FETCH;
        else       w_next = r_state;
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (w_opc == OPC_HALT)                                         w_next = S_DONE;
        else if (w_opc > OPC_LDI)                                      w_next = S_ERR;
        else if ((w_opc == OPC_DIV) && (w_rs2_val == {OP_SZ{1'b0}}))   w_next = S_ERR;
        else if (w_opc == OPC_LDI)                                     w_next = S_WB;
        else                                                           w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (iss_ready) w_next = S_WAIT;
        else           w_next = S_ISSUE;
      end
      S_WAIT: begin
        if (res_valid && res_err)  w_next = S_ERR;
        else if (res_valid)        w_next = S_WB;
        else                       w_next = S_WAIT;
      end
      S_WB: begin
        if (r_pc == PC_LAST) w_next = S_DONE;
        else                 w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Program store: not reset, writable only while the sequencer is parked
  always_ff @(posedge clk) begin
    if (w_we_ok) begin
      r_prog[prog_addr] <= prog_data;
    end
  end

  // PC, fetched instruction and writeback data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= {PW{1'b0}};
      r_instr   <= 16'd0;
      r_wb_data <= {OP_SZ{1'b0}};
    end else begin
      if (w_start_ok) begin
        r_pc <= {PW{1'b0}};
      end else if ((r_state == S_WB) && (r_pc != PC_LAST)) begin
        r_pc <= r_pc + PW'(1);
      end
      if (r_state == S_FETCH) begin
        r_instr <= r_prog[r_pc];
      end
      if ((r_state == S_DECODE) && (w_opc == OPC_LDI)) begin
        r_wb_data <= {{(OP_SZ-9){1'b0}}, r_instr[8:0]};
      end else if ((r_state == S_WAIT) && res_valid && !res_err) begin
        r_wb_data <= res_data;
      end
    end
  end

  // Register file writeback; stores and writes to r0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= {OP_SZ{1'b0}};
      end
    end else if ((r_state == S_WB) && (w_opc != OPC_STORE) && (w_rd != 3'd0)) begin
      r_regs[w_rd] <= r_wb_data;
    end
  end

  // Issue outputs: operands latched in DECODE and held until the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iss_valid   <= 1'b0;
      r_iss_op_code <= 4'd0;
      r_iss_op0     <= {OP_SZ{1'b0}};
      r_iss_op2     <= {OP_SZ{1'b0}};
    end else begin
      r_iss_valid <= (w_next == S_ISSUE);
      if ((r_state == S_DECODE) && (w_next == S_ISSUE)) begin
        r_iss_op_code <= w_opc;
        r_iss_op0     <= w_rs0_val;
        r_iss_op2     <= w_rs2_val;
      end
    end
  end

  // Status flags: busy, done pulse, sticky error with faulting PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_err_pc <= {PW{1'b0}};
    end else begin
      r_busy <= !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERR));
      r_done <= (w_next == S_DONE) && (r_state != S_DONE);
      if (w_start_ok) begin
        r_err    <= 1'b0;
        r_err_pc <= {PW{1'b0}};
      end else if ((w_next == S_ERR) && (r_state != S_ERR)) begin
        r_err    <= 1'b1;
        r_err_pc <= r_pc;
      end
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_op_code = r_iss_op_code;
  assign iss_op0     = r_iss_op0;
  assign iss_op2     = r_iss_op2;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_pc      = r_err_pc;
  assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: behavioural mcu model with an issue
// scoreboard, plus one task per scenario.
module tb_mcu_sequencer;
  localparam int OP_SZ = 32;
  localparam int PROG_DEPTH = 16;
  localparam int PW = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             prog_we;
  logic [PW-1:0]    prog_addr;
  logic [15:0]      prog_data;
  logic             start;
  logic             iss_valid;
  logic             iss_ready;
  logic [3:0]       iss_op_code;
  logic [OP_SZ-1:0] iss_op0;
  logic [OP_SZ-1:0] iss_op2;
  logic             res_valid;
  logic [OP_SZ-1:0] res_data;
  logic             res_err;
  logic             busy;
  logic             done;
  logic             err;
  logic [PW-1:0]    err_pc;
  logic [2:0]       dbg_sel;
  logic [OP_SZ-1:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int m_hs = 0;
  int m_valid_cycles = 0;
  bit m_stable = 1'b1;
  int m_ready_delay = 0;
  bit m_err_inject = 1'b0;
  int m_res_cnt = 0;
  logic [31:0] m_res = 32'd0;
  iss_t sb[$];
  iss_t sb_exp;
  iss_t m_first;
  logic [15:0] prog_buf[$];

  mcu_sequencer #(.OP_SZ(OP_SZ), .PROG_DEPTH(PROG_DEPTH), .REG_N(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_op_code(iss_op_code), .iss_op0(iss_op0),
    .iss_op2(iss_op2), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .busy(busy), .done(done), .err(err), .err_pc(err_pc),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [3:0] opc, input logic [2:0] rd,
                                      input logic [2:0] rs0, input logic [2:0] rs2);
    return {opc, rd, rs0, rs2, 3'd0};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'd9, rd, imm};
  endfunction

  function automatic logic [31:0] mcu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // mcu model: stalls iss_ready, checks issues against the scoreboard, returns results
  initial begin
    int wc;
    bit in_req;
    wc = 0;
    in_req = 1'b0;
    iss_ready = 1'b0;
    res_valid = 1'b0;
    res_err = 1'b0;
    res_data = 32'd0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      res_err = 1'b0;
      if (reset) begin
        iss_ready = 1'b0;
        wc = 0;
        in_req = 1'b0;
        m_res_cnt = 0;
      end else begin
        if (m_res_cnt > 0) begin
          m_res_cnt--;
          if (m_res_cnt == 0) begin
            res_valid = 1'b1;
            res_data = m_res;
            res_err = m_err_inject;
          end
        end
        if (iss_valid) begin
          if (!in_req) begin
            in_req = 1'b1;
            m_first = {iss_op_code, iss_op0, iss_op2};
          end else if ({iss_op_code, iss_op0, iss_op2} !== m_first) begin
            m_stable = 1'b0;
          end
          m_valid_cycles++;
          if (wc >= m_ready_delay) begin
            iss_ready = 1'b1;
            in_req = 1'b0;
            wc = 0;
            m_hs++;
            n_checks++;
            if (sb.size() == 0) begin
              n_errors++;
              $display("FAIL sb_unexpected_issue got op=%0d a=%0d b=%0d, required no issue",
                       iss_op_code, iss_op0, iss_op2);
            end else begin
              sb_exp = sb.pop_front();
              if ({iss_op_code, iss_op0, iss_op2} !== sb_exp) begin
                n_errors++;
                $display("FAIL sb_issue got op=%0d a=%0d b=%0d required op=%0d a=%0d b=%0d",
                         iss_op_code, iss_op0, iss_op2, sb_exp.op, sb_exp.a, sb_exp.b);
              end
            end
            m_res = mcu_fn(iss_op_code, iss_op0, iss_op2);
            m_res_cnt = 1;
          end else begin
            iss_ready = 1'b0;
            wc++;
          end
        end else begin
          iss_ready = 1'b0;
          wc = 0;
          in_req = 1'b0;
        end
      end
    end
  end

  // done pulse counter (sampled mid-cycle)
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    done_cnt = 0;
    m_hs = 0;
    m_valid_cycles = 0;
    m_stable = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic load_prog();
    foreach (prog_buf[i]) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = PW'(i);
      prog_data = prog_buf[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL run_timeout busy=%0b after %0d cycles, required 0", busy, cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog(input int budget);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(budget);
  endtask

  task automatic wait_issue(input int budget);
    int cyc;
    cyc = 0;
    while (!iss_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (iss_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL issue_timeout iss_valid=%0b after %0d cycles, required 1", iss_valid, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, iss_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags got busy/done/err/valid=%b required 0000", {busy, done, err, iss_valid});
    end
    n_checks++;
    if ({err_pc, iss_op_code, iss_op0, iss_op2} !== 72'd0) begin
      n_errors++;
      $display("FAIL reset_iss got err_pc=%0d op=%0d a=%0d b=%0d required 0", err_pc, iss_op_code, iss_op0, iss_op2);
    end
    for (int k = 0; k < 8; k++) begin
      dbg_sel = 3'(k);
      #1;
      n_checks++;
      if (dbg_data !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_reg r%0d got %0d required 0", k, dbg_data);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    pulse_reset();
    m_ready_delay = 0;
    prog_buf = '{ldi(3'd1, 9'd5), ldi(3'd2, 9'd3), enc(4'd0, 3'd3, 3'd1, 3'd2), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    clear_stats();
    sb.push_back('{4'd0, 32'd5, 32'd3});
    run_prog(200);
    dbg_sel = 3'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd8) begin
      n_errors++;
      $display("FAIL add_r3 got %0d required 8", dbg_data);
    end
    n_checks++;
    if (done_cnt !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL add_status got done_cnt=%0d err=%0b busy=%0b required 1 0 0", done_cnt, err, busy);
    end
    n_checks++;
    if (m_hs !== 1 || sb.size() !== 0) begin
      n_errors++;
      $display("FAIL add_handshakes got %0d pending=%0d required 1 0", m_hs, sb.size());
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    m_ready_delay = 4;
    clear_stats();
    sb.push_back('{4'd0, 32'd5, 32'd3});
    run_prog(200);
    n_checks++;
    if (m_valid_cycles !== 5 || m_stable !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_valid got cycles=%0d stable=%0b required 5 1", m_valid_cycles, m_stable);
    end
    n_checks++;
    if (m_hs !== 1) begin
      n_errors++;
      $display("FAIL stall_handshakes got %0d required 1", m_hs);
    end
    dbg_sel = 3'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd8) begin
      n_errors++;
      $display("FAIL stall_r3 got %0d required 8", dbg_data);
    end
    m_ready_delay = 0;
  endtask

  task automatic test_div_zero();
    pulse_reset();
    prog_buf = '{ldi(3'd1, 9'd7), enc(4'd3, 3'd3, 3'd1, 3'd0), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    clear_stats();
    run_prog(200);
    n_checks++;
    if (err !== 1'b1 || err_pc !== 4'd1) begin
      n_errors++;
      $display("FAIL div0_err got err=%0b err_pc=%0d required 1 1", err, err_pc);
    end
    n_checks++;
    if (m_valid_cycles !== 0 || done_cnt !== 0) begin
      n_errors++;
      $display("FAIL div0_noissue got valid_cycles=%0d done_cnt=%0d required 0 0", m_valid_cycles, done_cnt);
    end
    prog_buf = '{ldi(3'd1, 9'd6), enc(4'd0, 3'd3, 3'd1, 3'd1), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    clear_stats();
    sb.push_back('{4'd0, 32'd6, 32'd6});
    run_prog(200);
    n_checks++;
    if (err !== 1'b0 || done_cnt !== 1 || m_hs !== 1) begin
      n_errors++;
      $display("FAIL div0_rerun got err=%0b done_cnt=%0d hs=%0d required 0 1 1", err, done_cnt, m_hs);
    end
    dbg_sel = 3'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd12) begin
      n_errors++;
      $display("FAIL div0_rerun_r3 got %0d required 12", dbg_data);
    end
  endtask

  task automatic test_illegal();
    pulse_reset();
    prog_buf = '{16'hC000};
    load_prog();
    clear_stats();
    run_prog(200);
    n_checks++;
    if (err !== 1'b1 || err_pc !== 4'd0 || m_valid_cycles !== 0) begin
      n_errors++;
      $display("FAIL illegal_opc got err=%0b err_pc=%0d valid_cycles=%0d required 1 0 0", err, err_pc, m_valid_cycles);
    end
    prog_buf = '{ldi(3'd1, 9'd5), ldi(3'd3, 9'd9), enc(4'd0, 3'd3, 3'd1, 3'd1), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    clear_stats();
    m_err_inject = 1'b1;
    sb.push_back('{4'd0, 32'd5, 32'd5});
    run_prog(200);
    m_err_inject = 1'b0;
    n_checks++;
    if (err !== 1'b1 || err_pc !== 4'd2 || done_cnt !== 0 || m_hs !== 1) begin
      n_errors++;
      $display("FAIL res_err got err=%0b err_pc=%0d done_cnt=%0d hs=%0d required 1 2 0 1", err, err_pc, done_cnt, m_hs);
    end
    dbg_sel = 3'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd9) begin
      n_errors++;
      $display("FAIL res_err_rd got %0d required 9", dbg_data);
    end
  endtask

  task automatic test_full_ldi();
    logic [31:0] exp_r[8];
    pulse_reset();
    for (int k = 0; k < 8; k++) exp_r[k] = 32'd0;
    prog_buf.delete();
    for (int i = 0; i < PROG_DEPTH; i++) begin
      prog_buf.push_back(ldi(3'((i % 7) + 1), 9'(i * 10 + 1)));
      exp_r[(i % 7) + 1] = 32'(i * 10 + 1);
    end
    load_prog();
    clear_stats();
    run_prog(300);
    n_checks++;
    if (done_cnt !== 1 || err !== 1'b0 || m_valid_cycles !== 0) begin
      n_errors++;
      $display("FAIL full_done got done_cnt=%0d err=%0b valid_cycles=%0d required 1 0 0", done_cnt, err, m_valid_cycles);
    end
    for (int k = 0; k < 8; k++) begin
      dbg_sel = 3'(k);
      #1;
      n_checks++;
      if (dbg_data !== exp_r[k]) begin
        n_errors++;
        $display("FAIL full_reg r%0d got %0d required %0d", k, dbg_data, exp_r[k]);
      end
    end
    prog_buf = '{ldi(3'd1, 9'd4), enc(4'd0, 3'd0, 3'd1, 3'd1), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    clear_stats();
    sb.push_back('{4'd0, 32'd4, 32'd4});
    run_prog(200);
    dbg_sel = 3'd0;
    #1;
    n_checks++;
    if (dbg_data !== 32'd0 || m_hs !== 1) begin
      n_errors++;
      $display("FAIL rd_zero got r0=%0d hs=%0d required 0 1", dbg_data, m_hs);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    prog_buf = '{ldi(3'd1, 9'd5), ldi(3'd2, 9'd3), enc(4'd0, 3'd3, 3'd1, 3'd2), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    m_ready_delay = 20;
    sb.push_back('{4'd0, 32'd5, 32'd3});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_issue(50);
    #2;
    reset = 1'b1;
    dbg_sel = 3'd1;
    #1;
    n_checks++;
    if (iss_valid !== 1'b0 || busy !== 1'b0 || iss_op0 !== 32'd0 || dbg_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid got valid=%0b busy=%0b op0=%0d r1=%0d required 0 0 0 0", iss_valid, busy, iss_op0, dbg_data);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ready_delay = 0;
    m_res = 32'hDEAD_BEEF;
    m_res_cnt = 1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || iss_valid !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL late_res got busy=%0b valid=%0b err=%0b required 0 0 0", busy, iss_valid, err);
    end
    for (int k = 1; k < 8; k++) begin
      dbg_sel = 3'(k);
      #1;
      n_checks++;
      if (dbg_data !== 32'd0) begin
        n_errors++;
        $display("FAIL late_res_reg r%0d got %0d required 0", k, dbg_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    prog_buf = '{ldi(3'd1, 9'd5), enc(4'd0, 3'd2, 3'd1, 3'd1), enc(4'd15, 3'd0, 3'd0, 3'd0)};
    load_prog();
    m_ready_delay = 6;
    clear_stats();
    sb.push_back('{4'd0, 32'd5, 32'd5});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_issue(50);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = enc(4'd15, 3'd0, 3'd0, 3'd0);
    start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start = 1'b0;
    wait_idle(200);
    dbg_sel = 3'd2;
    #1;
    n_checks++;
    if (dbg_data !== 32'd10 || m_hs !== 1 || done_cnt !== 1) begin
      n_errors++;
      $display("FAIL busy_drop got r2=%0d hs=%0d done_cnt=%0d required 10 1 1", dbg_data, m_hs, done_cnt);
    end
    m_ready_delay = 0;
    clear_stats();
    sb.push_back('{4'd0, 32'd5, 32'd5});
    run_prog(200);
    n_checks++;
    if (m_hs !== 1 || done_cnt !== 1) begin
      n_errors++;
      $display("FAIL busy_we_dropped got hs=%0d done_cnt=%0d required 1 1", m_hs, done_cnt);
    end
    clear_stats();
    sb.push_back('{4'd0, 32'd5, 32'd5});
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = ldi(3'd4, 9'd77);
    start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start = 1'b0;
    wait_idle(200);
    dbg_sel = 3'd4;
    #1;
    n_checks++;
    if (dbg_data !== 32'd77 || m_hs !== 1 || sb.size() !== 0) begin
      n_errors++;
      $display("FAIL start_with_we got r4=%0d hs=%0d pending=%0d required 77 1 0", dbg_data, m_hs, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    prog_we = 1'b0;
    prog_addr = 4'd0;
    prog_data = 16'd0;
    start = 1'b0;
    dbg_sel = 3'd0;
    test_reset();
    test_add();
    test_stall();
    test_div_zero();
    test_illegal();
    test_full_ldi();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
